// File: rtl/axi_slave_wr_ingress.sv
// axi_slave_wr_ingress: AXI4 write ingress that reserves W FIFO space per burst, pads short bursts and returns B
module axi_slave_wr_ingress #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH = 8,
  parameter int LEN_WIDTH = 8,
  parameter int W_FIFO_DEPTH = 10,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int AVAIL_WIDTH = $clog2(W_FIFO_DEPTH) + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    awvalid,
  output logic                                    awready,
  input  logic [ID_WIDTH-1:0]                     awid,
  input  logic [ADDR_WIDTH-1:0]                   awaddr,
  input  logic [LEN_WIDTH-1:0]                    awlen,
  input  logic                                    wvalid,
  output logic                                    wready,
  input  logic [DATA_WIDTH-1:0]                   wdata,
  input  logic [STRB_WIDTH-1:0]                   wstrb,
  input  logic                                    wlast,
  output logic                                    bvalid,
  input  logic                                    bready,
  output logic [ID_WIDTH-1:0]                     bid,
  output logic [1:0]                              bresp,
  output logic                                    aw_fifo_wr_en,
  output logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH-1:0] aw_fifo_wr_data,
  input  logic                                    aw_fifo_full,
  output logic                                    w_fifo_wr_en,
  output logic [DATA_WIDTH+STRB_WIDTH-1:0]        w_fifo_wr_data,
  input  logic [AVAIL_WIDTH-1:0]                  w_fifo_available
);
  // Wide enough that awlen+1 never wraps, so an oversized burst can never look like it fits
  localparam int CMP_WIDTH = LEN_WIDTH + AVAIL_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, DATA, PAD, RESP} state_t;
  state_t state, state_nxt;
  logic [ID_WIDTH-1:0] cur_id;
  logic [LEN_WIDTH-1:0] cur_len;
  logic [LEN_WIDTH:0] beat_cnt;
  logic err;
  logic space_ok;
  logic at_end;
  assign space_ok = CMP_WIDTH'(w_fifo_available) >= CMP_WIDTH'(awlen) + CMP_WIDTH'(1);
  assign at_end = beat_cnt == {1'b0, cur_len};
  // State register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  // Channel handshakes, FIFO pushes and next state
  always_comb begin
    awready = !rst && state == IDLE && !aw_fifo_full && space_ok;
    wready = state == DATA;
    bvalid = state == RESP;
    bid = cur_id;
    bresp = err ? 2'b10 : 2'b00;
    aw_fifo_wr_en = awvalid && awready;
    aw_fifo_wr_data = {awid, awaddr, awlen};
    w_fifo_wr_en = (wready && wvalid) || state == PAD;
    w_fifo_wr_data = wready ? {wdata, wstrb} : '0;
    state_nxt = state;
    case (state)
      IDLE: state_nxt = aw_fifo_wr_en ? DATA : IDLE;
      DATA: state_nxt = !wvalid ? DATA : at_end ? RESP : wlast ? PAD : DATA;
      PAD: state_nxt = at_end ? RESP : PAD;
      default: state_nxt = bready ? IDLE : RESP;
    endcase
  end
  // Burst context: every W push advances the beat count; wlast disagreeing with the count flags SLVERR
  always_ff @(posedge clk)
    if (rst) begin
      cur_id <= '0;
      cur_len <= '0;
      beat_cnt <= '0;
      err <= 1'b0;
    end else if (aw_fifo_wr_en) begin
      cur_id <= awid;
      cur_len <= awlen;
      beat_cnt <= '0;
      err <= 1'b0;
    end else if (w_fifo_wr_en) begin
      beat_cnt <= beat_cnt + (LEN_WIDTH + 1)'(1);
      err <= err | (state == DATA && (at_end ? !wlast : wlast));
    end
endmodule

// File: tb/tb_axi_slave_wr_ingress.sv
// tb_axi_slave_wr_ingress: scoreboard bench for the AXI write ingress
module tb_axi_slave_wr_ingress;
  localparam int AW = 64, DW = 256, SW = DW / 8, IW = 8, LW = 8, DEPTH = 10;
  localparam int AVW = $clog2(DEPTH) + 1;
  logic clk = 0, rst = 1;
  logic awvalid = 0, awready;
  logic [IW-1:0] awid = 0;
  logic [AW-1:0] awaddr = 0;
  logic [LW-1:0] awlen = 0;
  logic wvalid = 0, wready, wlast = 0;
  logic [DW-1:0] wdata = 0;
  logic [SW-1:0] wstrb = 0;
  logic bvalid, bready = 1;
  logic [IW-1:0] bid;
  logic [1:0] bresp;
  logic aw_fifo_wr_en, aw_fifo_full = 0;
  logic [IW+AW+LW-1:0] aw_fifo_wr_data;
  logic w_fifo_wr_en;
  logic [DW+SW-1:0] w_fifo_wr_data;
  logic [AVW-1:0] w_fifo_available = AVW'(DEPTH);
  int n_checks = 0, n_fail = 0;
  logic [IW+AW+LW-1:0] exp_aw[$];
  logic [DW+SW-1:0] exp_w[$];
  logic [IW+1:0] exp_b[$];

  axi_slave_wr_ingress #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .W_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .aw_fifo_wr_en(aw_fifo_wr_en), .aw_fifo_wr_data(aw_fifo_wr_data), .aw_fifo_full(aw_fifo_full),
    .w_fifo_wr_en(w_fifo_wr_en), .w_fifo_wr_data(w_fifo_wr_data), .w_fifo_available(w_fifo_available)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int k);
    return {8{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic logic [SW-1:0] beat_strb(input int k);
    return SW'(32'hF0F0_0F0F ^ 32'(k * 3));
  endfunction

  // Monitor: pops the scoreboard whenever the DUT pushes a FIFO or completes a B handshake
  initial forever begin
    @(negedge clk);
    #2;
    if (aw_fifo_wr_en) begin
      if (exp_aw.size() == 0) check("aw_push_unexpected", aw_fifo_wr_en, 1'b0);
      else check("aw_push", aw_fifo_wr_data, exp_aw.pop_front());
    end
    if (w_fifo_wr_en) begin
      if (exp_w.size() == 0) check("w_push_unexpected", w_fifo_wr_en, 1'b0);
      else check("w_push", w_fifo_wr_data, exp_w.pop_front());
    end
    if (bvalid && bready) begin
      if (exp_b.size() == 0) check("b_unexpected", bvalid, 1'b0);
      else check("b_resp", {bid, bresp}, exp_b.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len, output int waited);
    logic ok;
    ok = 0;
    awvalid = 1; awid = id; awaddr = addr; awlen = len;
    for (waited = 0; waited < 40; waited++) begin
      @(negedge clk);
      ok = awready;
      if (ok) exp_aw.push_back({id, addr, len});
      tick();
      if (ok) break;
    end
    if (!ok) check("aw_timeout", ok, 1'b1);
    awvalid = 0;
  endtask

  task automatic w_beat(input logic v, input int k, input logic last);
    wvalid = v; wdata = beat_data(k); wstrb = beat_strb(k); wlast = last;
    if (v) exp_w.push_back({beat_data(k), beat_strb(k)});
    @(negedge clk);
    check("wready_in_data", wready, 1'b1);
    tick();
    wvalid = 0; wlast = 0;
  endtask

  task automatic pad_cycles(input int p);
    for (int i = 0; i < p; i++) begin
      exp_w.push_back('0);
      @(negedge clk);
      check("wready_in_pad", wready, 1'b0);
      tick();
    end
  endtask

  task automatic wait_b(input logic [IW-1:0] id, input logic [1:0] resp, input int exp_lat);
    logic ok;
    int lat;
    ok = 0;
    exp_b.push_back({id, resp});
    for (lat = 0; lat < 20; lat++) begin
      @(negedge clk);
      ok = bvalid;
      tick();
      if (ok) break;
    end
    check("bvalid_latency", lat, exp_lat);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_awready"}, awready, 1'b0);
    check({name, "_wready"}, wready, 1'b0);
    check({name, "_bvalid"}, bvalid, 1'b0);
    check({name, "_aw_wr_en"}, aw_fifo_wr_en, 1'b0);
    check({name, "_w_wr_en"}, w_fifo_wr_en, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int waited;
    tick();
    tick();
    @(negedge clk);
    check_quiet("reset");
    check("reset_bid", bid, 8'h00);
    check("reset_bresp", bresp, 2'b00);
    tick();
    rst = 0;
    // Single-beat burst
    aw_send(8'h11, 64'h1000, 8'd0, waited);
    check("single_aw_wait", waited, 0);
    w_beat(1, 0, 1);
    wait_b(8'h11, 2'b00, 0);
    // Four beats with wvalid bubbles
    aw_send(8'h22, 64'h2000, 8'd3, waited);
    check("bubble_aw_wait", waited, 0);
    w_beat(1, 1, 0);
    w_beat(0, 99, 0);
    w_beat(1, 2, 0);
    w_beat(1, 3, 0);
    w_beat(0, 98, 0);
    w_beat(1, 4, 1);
    wait_b(8'h22, 2'b00, 0);
    // Early wlast: two data beats then four padding beats
    aw_send(8'h33, 64'h3000, 8'd5, waited);
    w_beat(1, 5, 0);
    w_beat(1, 6, 1);
    pad_cycles(4);
    wait_b(8'h33, 2'b10, 0);
    // Missing wlast, with B held off to observe stability
    aw_send(8'h44, 64'h4000, 8'd2, waited);
    bready = 0;
    w_beat(1, 7, 0);
    w_beat(1, 8, 0);
    w_beat(1, 9, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("miss_bvalid_hold", bvalid, 1'b1);
      check("miss_bresp_hold", bresp, 2'b10);
      check("miss_wready", wready, 1'b0);
      tick();
    end
    bready = 1;
    wait_b(8'h44, 2'b10, 0);
    // Insufficient W FIFO space, then exactly enough
    w_fifo_available = AVW'(3);
    awvalid = 1; awid = 8'h55; awaddr = 64'h5000; awlen = 8'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("space_block_awready", awready, 1'b0);
      tick();
    end
    w_fifo_available = AVW'(4);
    aw_send(8'h55, 64'h5000, 8'd3, waited);
    check("space_accept_wait", waited, 0);
    for (int k = 10; k < 14; k++) w_beat(1, k, k == 13);
    wait_b(8'h55, 2'b00, 0);
    w_fifo_available = AVW'(DEPTH);
    // Oversized burst never fits the W FIFO
    awvalid = 1; awid = 8'h5A; awlen = 8'd255;
    @(negedge clk);
    check("oversize_awready", awready, 1'b0);
    tick();
    // AW FIFO full blocks accept
    aw_fifo_full = 1;
    awvalid = 1; awid = 8'h5B; awaddr = 64'h5B00; awlen = 8'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("awfull_awready", awready, 1'b0);
      tick();
    end
    aw_fifo_full = 0;
    aw_send(8'h5B, 64'h5B00, 8'd0, waited);
    check("awfull_accept_wait", waited, 0);
    w_beat(1, 20, 1);
    wait_b(8'h5B, 2'b00, 0);
    // Reset in the middle of an 8-beat burst
    aw_send(8'h66, 64'h6000, 8'd7, waited);
    w_beat(1, 30, 0);
    w_beat(1, 31, 0);
    rst = 1;
    tick();
    @(negedge clk);
    check_quiet("midrst");
    check("midrst_bresp", bresp, 2'b00);
    tick();
    rst = 0;
    aw_send(8'h77, 64'h7000, 8'd0, waited);
    check("post_rst_aw_wait", waited, 0);
    w_beat(1, 40, 1);
    wait_b(8'h77, 2'b00, 0);
    tick();
    tick();
    check("aw_queue_drained", exp_aw.size(), 0);
    check("w_queue_drained", exp_w.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
